// File: rtl/mul_div_unit_if.sv
// E-stage MDU connection: forwarded operands and op code in, stall, HI/LO and
// mfhi/mflo read data out.
interface mul_div_unit_if;
    logic [3:0]  E_mdu_op;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        D_is_mdu;
    logic        busy;
    logic        mdu_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_mdu_rd;

    modport master (
        output E_mdu_op, E_rs_data, E_rt_data, D_is_mdu,
        input  busy, mdu_stall, HI, LO, E_mdu_rd
    );

    modport slave (
        input  E_mdu_op, E_rs_data, E_rt_data, D_is_mdu,
        output busy, mdu_stall, HI, LO, E_mdu_rd
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO. The result is computed at start into
// shadow registers and committed to HI/LO only when the latency counter expires.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        shadow_hi_q, shadow_hi_d;
    logic [31:0]        shadow_lo_q, shadow_lo_d;
    logic               shadow_wr_q, shadow_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               busy;
    logic               commit;
    logic               start;
    logic               is_mult_op;
    logic               is_signed;

    logic [31:0]        rs, rt;
    logic [63:0]        mul_a, mul_b, product;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag;
    logic [31:0]        quot, rem;
    logic [31:0]        res_hi, res_lo;

    assign rs = bus.E_rs_data;
    assign rt = bus.E_rt_data;

    assign is_mult_op = (bus.E_mdu_op == OP_MULT) || (bus.E_mdu_op == OP_MULTU);
    assign is_signed  = (bus.E_mdu_op == OP_MULT) || (bus.E_mdu_op == OP_DIV);
    assign start      = (bus.E_mdu_op >= OP_MULT) && (bus.E_mdu_op <= OP_DIVU) && !busy;

    // Sign/zero-extend to 64 bits so one unsigned multiplier covers mult and multu.
    assign mul_a   = is_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
    assign mul_b   = is_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
    assign product = mul_a * mul_b;

    // Signed divide via magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000.
    assign a_neg = is_signed && rs[31];
    assign b_neg = is_signed && rt[31];
    assign a_mag = a_neg ? (32'd0 - rs) : rs;
    assign b_mag = b_neg ? (32'd0 - rt) : rt;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    assign res_hi = is_mult_op ? product[63:32] : rem;
    assign res_lo = is_mult_op ? product[31:0]  : quot;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StBusy;
            StBusy: if (cnt_q == CNT_W'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (state_q == StBusy);
        commit = busy && (cnt_q == CNT_W'(1));
    end

    // Datapath next state
    always_comb begin
        cnt_d       = cnt_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        shadow_wr_d = shadow_wr_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (start) begin
            cnt_d       = is_mult_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            shadow_hi_d = res_hi;
            shadow_lo_d = res_lo;
            // Divide by zero still occupies the unit but leaves HI/LO untouched.
            shadow_wr_d = is_mult_op || (rt != 32'd0);
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (commit && shadow_wr_q) begin
                hi_d = shadow_hi_q;
                lo_d = shadow_lo_q;
            end
        end else if (bus.E_mdu_op == OP_MTHI) begin
            hi_d = rs;
        end else if (bus.E_mdu_op == OP_MTLO) begin
            lo_d = rs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
            shadow_wr_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            shadow_wr_q <= shadow_wr_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.mdu_stall = bus.D_is_mdu && (busy || start);
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.E_mdu_rd  = (bus.E_mdu_op == OP_MFHI) ? hi_q :
                           (bus.E_mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised bench for mul_div_unit: a cycle-level arithmetic model predicts every
// output each cycle, with hand-computed literal checks for the directed cases.
module tb_mul_div_unit;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk;
    logic rst_n;
    mul_div_unit_if bus ();

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: committed registers, remaining busy cycles, pending result.
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    bit          m_res_wr;
    int          m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_hi = 0; m_lo = 0; m_res_hi = 0; m_res_lo = 0; m_res_wr = 0; m_left = 0;
    endtask

    task automatic m_edge();
        logic [3:0]  op;
        logic [31:0] rs, rt;
        int          srs, srt;
        longint      sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        op = bus.E_mdu_op; rs = bus.E_rs_data; rt = bus.E_rt_data;
        srs = rs; srt = rt; sa = srs; sb = srt;
        ua = {32'd0, rs}; ub = {32'd0, rt};
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_res_wr) begin
                m_hi = m_res_hi; m_lo = m_res_lo;
            end
        end else begin
            case (op)
                4'd1: begin
                    sp = sa * sb; m_res_hi = sp[63:32]; m_res_lo = sp[31:0];
                    m_res_wr = 1; m_left = MC;
                end
                4'd2: begin
                    up = ua * ub; m_res_hi = up[63:32]; m_res_lo = up[31:0];
                    m_res_wr = 1; m_left = MC;
                end
                4'd3: begin
                    m_left = DC; m_res_wr = (rt != 0);
                    if (rt != 0) begin
                        sq = sa / sb; sr = sa % sb;
                        m_res_lo = sq[31:0]; m_res_hi = sr[31:0];
                    end
                end
                4'd4: begin
                    m_left = DC; m_res_wr = (rt != 0);
                    if (rt != 0) begin
                        m_res_lo = 32'(ua / ub); m_res_hi = 32'(ua % ub);
                    end
                end
                4'd5: m_hi = rs;
                4'd6: m_lo = rs;
                default: ;
            endcase
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            logic e_busy, e_start, e_stall;
            logic [31:0] e_rd;
            e_busy  = (m_left > 0);
            e_start = (bus.E_mdu_op >= 4'd1) && (bus.E_mdu_op <= 4'd4) && !e_busy;
            e_stall = bus.D_is_mdu && (e_busy || e_start);
            e_rd    = (bus.E_mdu_op == 4'd7) ? m_hi : (bus.E_mdu_op == 4'd8) ? m_lo : 32'd0;
            chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
            chk("mdu_stall", {31'd0, bus.mdu_stall}, {31'd0, e_stall});
            chk("HI", bus.HI, m_hi);
            chk("LO", bus.LO, m_lo);
            chk("E_mdu_rd", bus.E_mdu_rd, e_rd);
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic d);
        bus.E_mdu_op = op; bus.E_rs_data = rs; bus.E_rt_data = rt; bus.D_is_mdu = d;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) begin
            drive(4'd0, $urandom, $urandom, d);
            tick();
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] rt;
        logic [3:0]  op;
        rst_n = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_HI", bus.HI, 32'd0);
        chk("reset_LO", bus.LO, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // mult -3 * 5
        drive(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'd0, 32'd0, 32'd0, 1'b0); #1;
            chk("mult_busy_window", {31'd0, bus.busy}, 32'd1);
            tick();
        end
        chk("mult_done_busy", {31'd0, bus.busy}, 32'd0);
        chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
        chk("mult_LO", bus.LO, 32'hFFFF_FFF1);

        // multu 0xFFFFFFFF * 2
        drive(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0); tick(); idle(5, 1'b0);
        chk("multu_HI", bus.HI, 32'h0000_0001);
        chk("multu_LO", bus.LO, 32'hFFFF_FFFE);

        // div -7 / 2
        drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0); tick(); idle(9, 1'b0);
        chk("div_not_yet", bus.LO, 32'hFFFF_FFFE);
        idle(1, 1'b0);
        chk("div_LO", bus.LO, 32'hFFFF_FFFD);
        chk("div_HI", bus.HI, 32'hFFFF_FFFF);

        // mthi, then divide by zero leaves HI/LO alone
        drive(4'd5, 32'h0000_1234, 32'd0, 1'b0); tick();
        drive(4'd3, 32'd77, 32'd0, 1'b0); tick(); idle(10, 1'b0);
        chk("div0_busy", {31'd0, bus.busy}, 32'd0);
        chk("div0_HI", bus.HI, 32'h0000_1234);
        chk("div0_LO", bus.LO, 32'hFFFF_FFFD);
        drive(4'd8, 32'd0, 32'd0, 1'b1); #1;
        chk("mflo_rd", bus.E_mdu_rd, 32'hFFFF_FFFD); tick();
        drive(4'd7, 32'd0, 32'd0, 1'b1); #1;
        chk("mfhi_rd", bus.E_mdu_rd, 32'h0000_1234); tick();

        // signed overflow divide
        drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); tick(); idle(10, 1'b0);
        chk("ovf_LO", bus.LO, 32'h8000_0000);
        chk("ovf_HI", bus.HI, 32'h0000_0000);

        // stall with D_is_mdu held
        cnt = 0;
        drive(4'd3, 32'd50, 32'd3, 1'b1); #1; cnt += int'(bus.mdu_stall); tick();
        for (int i = 0; i < 10; i++) begin
            drive(4'd0, 32'd0, 32'd0, 1'b1); #1; cnt += int'(bus.mdu_stall); tick();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b1); #1;
        chk("stall_after_commit", {31'd0, bus.mdu_stall}, 32'd0);
        chk("stall_cycles", cnt, 32'd11);
        chk("stall_div_LO", bus.LO, 32'd16);
        cnt = 0;
        drive(4'd4, 32'd50, 32'd3, 1'b0); #1; cnt += int'(bus.mdu_stall); tick();
        for (int i = 0; i < 10; i++) begin
            drive(4'd0, 32'd0, 32'd0, 1'b0); #1; cnt += int'(bus.mdu_stall); tick();
        end
        chk("no_stall_cycles", cnt, 32'd0);

        // reset mid-operation at T+3
        drive(4'd1, 32'd1000, 32'd1000, 1'b0); tick(); idle(2, 1'b0);
        rst_n = 1'b0; m_reset(); #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_HI", bus.HI, 32'd0);
        chk("midrst_LO", bus.LO, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        idle(8, 1'b0);
        chk("midrst_no_commit_HI", bus.HI, 32'd0);
        chk("midrst_no_commit_LO", bus.LO, 32'd0);

        // back-to-back: divu issued in the first idle cycle after a mult
        drive(4'd1, 32'd7, 32'd9, 1'b1); tick(); idle(5, 1'b1);
        chk("b2b_mult_LO", bus.LO, 32'd63);
        drive(4'd4, 32'd100, 32'd7, 1'b1); #1;
        chk("b2b_start_stall", {31'd0, bus.mdu_stall}, 32'd1);
        tick(); idle(10, 1'b1);
        chk("b2b_divu_LO", bus.LO, 32'd14);
        chk("b2b_divu_HI", bus.HI, 32'd2);

        // random traffic, including ops arriving while busy
        for (int i = 0; i < 1500; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'(  $urandom_range(0, 15))
                                             : 4'($urandom_range(1, 8));
            case ($urandom_range(0, 7))
                0: rt = 32'd0;
                1: rt = 32'hFFFF_FFFF;
                2: rt = 32'($urandom_range(1, 9));
                default: rt = $urandom;
            endcase
            drive(op, ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom, rt,
                  1'($urandom_range(0, 1)));
            tick();
        end
        idle(12, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
